// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache controller:
// FSM state encoding, default geometry and one-hot/index conversion.
package cache_pkg;

  localparam int WAYS_DEF  = 2;
  localparam int SETS_DEF  = 64;
  localparam int BEATS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB_AW,
    ST_WB_W,
    ST_WB_B,
    ST_RF_AR,
    ST_RF_R,
    ST_FL_SCAN
  } state_t;

  // Lowest set bit wins, so a malformed multi-hot input still maps to one way.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] idx2oh(input logic [2:0] i);
    return 8'b1 << i;
  endfunction

endpackage

// File: rtl/cache_rr_victim.sv
// Victim way selection: lowest invalid way first, otherwise the per-set
// round-robin pointer, which advances past the way just refilled.
module cache_rr_victim
  import cache_pkg::*;
#(
  parameter int  WAYS  = WAYS_DEF,
  parameter int  SETS  = SETS_DEF,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WAYS-1:0]  i_valid_way,
  input  logic             i_upd,
  input  logic [WAY_W-1:0] i_upd_way,
  output logic [WAYS-1:0]  o_victim
);

  logic [WAY_W-1:0] r_ptr [SETS];
  logic [WAYS-1:0]  w_inv;
  logic [WAY_W-1:0] w_ptr_nxt;

  assign w_inv     = ~i_valid_way;
  assign w_ptr_nxt = (i_upd_way == WAY_W'(WAYS - 1)) ? '0 : i_upd_way + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
    end else if (i_upd) begin
      r_ptr[i_idx] <= w_ptr_nxt;
    end
  end

  always_comb begin
    if (|w_inv) o_victim = w_inv & (~w_inv + 1'b1);
    else        o_victim = WAYS'(idx2oh(3'(r_ptr[i_idx])));
  end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// Sequencing FSM for an N-way write-back/write-allocate cache: hit service,
// victim writeback, multi-beat refill with replay, and a full flush walk.
module cache_ctrl_assoc
  import cache_pkg::*;
#(
  parameter int  WAYS   = WAYS_DEF,
  parameter int  SETS   = SETS_DEF,
  parameter int  BEATS  = BEATS_DEF,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [IDX_W-1:0]  cpu_idx,
  output logic              cpu_ready,
  output logic              cpu_done,
  input  logic [WAYS-1:0]   hit_way,
  input  logic [WAYS-1:0]   dirty_way,
  input  logic [WAYS-1:0]   valid_way,
  output logic [IDX_W-1:0]  arr_idx,
  output logic [WAYS-1:0]   way_sel,
  output logic              rd_data,
  output logic              wr_data,
  output logic              fill_we,
  output logic              tag_we,
  output logic              dirty_set,
  output logic              dirty_clr,
  output logic [BEAT_W-1:0] beat,
  output logic              arvalid,
  input  logic              arready,
  input  logic              rvalid,
  output logic              rready,
  output logic              awvalid,
  input  logic              awready,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done
);

  state_t             r_state, w_nxt_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_we;
  logic [BEAT_W-1:0]  r_beat;
  logic [IDX_W-1:0]   r_fl_set;
  logic [WAY_W-1:0]   r_fl_way;
  logic               r_flushing;
  logic [WAYS-1:0]    r_victim;

  logic [WAYS-1:0]    w_victim;
  logic [WAYS-1:0]    w_hit_oh;
  logic [WAYS-1:0]    w_fl_oh;
  logic               w_last_beat;
  logic               w_last_pair;
  logic               w_fl_dirty;
  logic               w_rr_upd;
  logic [WAY_W-1:0]   w_upd_way;

  assign w_hit_oh    = hit_way & (~hit_way + 1'b1);
  assign w_fl_oh     = WAYS'(idx2oh(3'(r_fl_way)));
  assign w_fl_dirty  = |(valid_way & dirty_way & w_fl_oh);
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_last_pair = (r_fl_way == WAY_W'(WAYS - 1)) && (r_fl_set == IDX_W'(SETS - 1));
  assign w_upd_way   = WAY_W'(oh2idx(8'(r_victim)));
  assign beat        = r_beat;
  assign flush_busy  = r_flushing;

  cache_rr_victim #(.WAYS(WAYS), .SETS(SETS)) u_victim (
    .clk         (clk),
    .rst         (rst),
    .i_idx       (r_idx),
    .i_valid_way (valid_way),
    .i_upd       (w_rr_upd),
    .i_upd_way   (w_upd_way),
    .o_victim    (w_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_beat     <= '0;
      r_fl_set   <= '0;
      r_fl_way   <= '0;
      r_flushing <= 1'b0;
      r_victim   <= '0;
    end else begin
      r_state <= w_nxt_state;
      case (r_state)
        ST_IDLE: begin
          if (flush_req) begin
            r_flushing <= 1'b1;
          end else if (cpu_valid) begin
            r_idx <= cpu_idx;
            r_we  <= cpu_we;
          end
        end
        ST_LOOKUP: if (~|hit_way) r_victim <= w_victim;
        ST_WB_AW:  if (awready) r_beat <= '0;
        ST_WB_W:   if (wready) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        ST_RF_AR:  if (arready) r_beat <= '0;
        ST_RF_R:   if (rvalid) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        ST_FL_SCAN: begin
          // A dirty pair is written back and then revisited, so the walk only
          // advances on a clean pair; counters wrap to zero after the last one.
          if (w_fl_dirty) begin
            r_idx    <= r_fl_set;
            r_victim <= w_fl_oh;
          end else begin
            if (r_fl_way == WAY_W'(WAYS - 1)) begin
              r_fl_way <= '0;
              r_fl_set <= r_fl_set + 1'b1;
            end else begin
              r_fl_way <= r_fl_way + 1'b1;
            end
            if (w_last_pair) r_flushing <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    cpu_ready   = 1'b0;
    cpu_done    = 1'b0;
    arr_idx     = r_idx;
    way_sel     = '0;
    rd_data     = 1'b0;
    wr_data     = 1'b0;
    fill_we     = 1'b0;
    tag_we      = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    bready      = 1'b0;
    flush_done  = 1'b0;
    w_rr_upd    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cpu_ready = 1'b1;
        arr_idx   = cpu_idx;
        if (flush_req)      w_nxt_state = ST_FL_SCAN;
        else if (cpu_valid) w_nxt_state = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (|hit_way) begin
          way_sel     = w_hit_oh;
          rd_data     = ~r_we;
          wr_data     = r_we;
          dirty_set   = r_we;
          cpu_done    = 1'b1;
          w_nxt_state = ST_IDLE;
        end else if (|(w_victim & valid_way & dirty_way)) begin
          w_nxt_state = ST_WB_AW;
        end else begin
          w_nxt_state = ST_RF_AR;
        end
      end
      ST_WB_AW: begin
        awvalid = 1'b1;
        way_sel = r_victim;
        if (awready) w_nxt_state = ST_WB_W;
      end
      ST_WB_W: begin
        wvalid  = 1'b1;
        wlast   = w_last_beat;
        way_sel = r_victim;
        if (wready && w_last_beat) w_nxt_state = ST_WB_B;
      end
      ST_WB_B: begin
        bready  = 1'b1;
        way_sel = r_victim;
        if (bvalid) begin
          dirty_clr   = 1'b1;
          w_nxt_state = r_flushing ? ST_FL_SCAN : ST_RF_AR;
        end
      end
      ST_RF_AR: begin
        arvalid = 1'b1;
        way_sel = r_victim;
        if (arready) w_nxt_state = ST_RF_R;
      end
      ST_RF_R: begin
        rready  = 1'b1;
        way_sel = r_victim;
        if (rvalid) begin
          fill_we = 1'b1;
          if (w_last_beat) begin
            tag_we      = 1'b1;
            w_rr_upd    = 1'b1;
            w_nxt_state = ST_LOOKUP;
          end
        end
      end
      ST_FL_SCAN: begin
        arr_idx = r_fl_set;
        way_sel = w_fl_oh;
        if (w_fl_dirty) begin
          w_nxt_state = ST_WB_AW;
        end else if (w_last_pair) begin
          flush_done  = 1'b1;
          w_nxt_state = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_LOOKUP)
      assert ($onehot0(hit_way)) else $error("multiple hit_way bits: %b", hit_way);
  end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench for cache_ctrl_assoc (WAYS=2, SETS=64, BEATS=4) with a
// behavioural tag/valid/dirty array and a simple memory responder.
module tb_cache_ctrl_assoc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_valid = 1'b0, cpu_we = 1'b0;
  logic [5:0] cpu_idx = '0;
  logic       cpu_ready, cpu_done;
  logic [1:0] hit_way, dirty_way, valid_way;
  logic [5:0] arr_idx;
  logic [1:0] way_sel;
  logic       rd_data, wr_data, fill_we, tag_we, dirty_set, dirty_clr;
  logic [1:0] beat;
  logic       arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic       awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
  logic       bvalid = 1'b0, bready;
  logic       flush_req = 1'b0, flush_busy, flush_done;

  cache_ctrl_assoc #(.WAYS(2), .SETS(64), .BEATS(4)) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_idx(cpu_idx),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .hit_way(hit_way), .dirty_way(dirty_way),
    .valid_way(valid_way), .arr_idx(arr_idx), .way_sel(way_sel), .rd_data(rd_data),
    .wr_data(wr_data), .fill_we(fill_we), .tag_we(tag_we), .dirty_set(dirty_set),
    .dirty_clr(dirty_clr), .beat(beat), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .awvalid(awvalid), .awready(awready),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .bvalid(bvalid), .bready(bready),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  logic [14:0] outs;
  assign outs = {cpu_done, rd_data, wr_data, fill_we, tag_we, dirty_set, dirty_clr,
                 arvalid, rready, awvalid, wvalid, wlast, bready, flush_busy, flush_done};

  int n_tests = 0;
  int n_fail  = 0;

  // Array model
  logic m_valid [64][2];
  logic m_dirty [64][2];
  int   m_tag   [64][2];
  int   cur_tag = 0;
  logic pl_req = 1'b0, pl_clr = 1'b0, pl_dirty = 1'b0;
  logic [5:0] pl_set = '0;
  int   pl_way = 0, pl_tag = 0;

  always_comb begin
    hit_way = '0; valid_way = '0; dirty_way = '0;
    for (int w = 0; w < 2; w++) begin
      valid_way[w] = m_valid[arr_idx][w];
      dirty_way[w] = m_dirty[arr_idx][w];
      hit_way[w]   = m_valid[arr_idx][w] && (m_tag[arr_idx][w] == cur_tag);
    end
  end

  // Memory responder
  int   ar_delay = 0;
  int   ar_cnt = 0;
  logic w_toggle = 1'b0, w_tog = 1'b0;

  always @(negedge clk) begin
    if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
    else begin arready = 1'b0; ar_cnt = 0; end
    rvalid  = rready;
    awready = awvalid;
    if (wvalid) begin w_tog = ~w_tog; wready = w_toggle ? w_tog : 1'b1; end
    else begin wready = 1'b0; w_tog = 1'b0; end
    bvalid = bready;
  end

  // Monitor: array updates and transfer logs
  logic [7:0] tag_log[$];
  logic [7:0] clr_log[$];
  logic [1:0] fill_log[$];
  logic [2:0] w_log[$];
  int   n_ar = 0, n_aw = 0, w_drop = 0;
  logic in_w = 1'b0;

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int s = 0; s < 64; s++)
        for (int w = 0; w < 2; w++) begin
          m_valid[s][w] <= 1'b0; m_dirty[s][w] <= 1'b0; m_tag[s][w] <= -1;
        end
    end else if (pl_req) begin
      m_valid[pl_set][pl_way] <= 1'b1;
      m_dirty[pl_set][pl_way] <= pl_dirty;
      m_tag[pl_set][pl_way]   <= pl_tag;
    end
    for (int w = 0; w < 2; w++) begin
      if (way_sel[w]) begin
        if (tag_we) begin
          m_tag[arr_idx][w] <= cur_tag; m_valid[arr_idx][w] <= 1'b1; m_dirty[arr_idx][w] <= 1'b0;
        end
        if (dirty_set) m_dirty[arr_idx][w] <= 1'b1;
        if (dirty_clr) m_dirty[arr_idx][w] <= 1'b0;
      end
    end
    if (tag_we)    tag_log.push_back({arr_idx, way_sel});
    if (dirty_clr) clr_log.push_back({arr_idx, way_sel});
    if (fill_we)   fill_log.push_back(beat);
    if (arvalid && arready) n_ar++;
    if (in_w && !wvalid) w_drop++;
    if (rst) in_w <= 1'b0;
    else if (awvalid && awready) begin n_aw++; in_w <= 1'b1; end
    else if (wvalid && wready && wlast) in_w <= 1'b0;
    if (wvalid && wready) w_log.push_back({wlast, beat});
  end

  task automatic preload(input logic [5:0] s, input int w, input int tag, input logic d);
    @(negedge clk);
    pl_set = s; pl_way = w; pl_tag = tag; pl_dirty = d; pl_req = 1'b1;
    @(negedge clk);
    pl_req = 1'b0;
  endtask

  task automatic model_clear();
    @(negedge clk); pl_clr = 1'b1;
    @(negedge clk); pl_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cpu_valid = 1'b0; flush_req = 1'b0; cpu_idx = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request; lat counts cycles from the request cycle to cpu_done inclusive.
  task automatic do_req(input logic we, input logic [5:0] idx, input int tag,
                        output int lat, output logic [1:0] ws, output logic [2:0] fl,
                        output logic ok);
    @(negedge clk);
    cur_tag = tag; cpu_valid = 1'b1; cpu_we = we; cpu_idx = idx;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0; cpu_idx = '0;
    lat = 2; ok = 1'b0; ws = '0; fl = '0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (cpu_done) begin ok = 1'b1; ws = way_sel; fl = {rd_data, wr_data, dirty_set}; end
      else begin @(negedge clk); lat++; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_ready got %b exp 1", cpu_ready); end
    n_tests++; if (outs !== 15'h0) begin n_fail++; $display("FAIL reset_outs got %h exp 0", outs); end
    n_tests++; if (way_sel !== 2'b00 || beat !== 2'd0) begin n_fail++; $display("FAIL reset_way_beat got %b/%0d exp 00/0", way_sel, beat); end
    n_tests++; if (arr_idx !== 6'd0) begin n_fail++; $display("FAIL reset_arr_idx got %0d exp 0", arr_idx); end
    rst = 1'b0;
  endtask

  task automatic test_load_miss();
    int lat; logic [1:0] ws; logic [2:0] fl; logic ok;
    int f0, t0, a0, w0; logic [7:0] fv;
    f0 = fill_log.size(); t0 = tag_log.size(); a0 = n_ar; w0 = n_aw;
    ar_delay = 2;
    do_req(1'b0, 6'd5, 100, lat, ws, fl, ok);
    fv = '0;
    for (int i = 0; i < 4; i++) fv[i*2 +: 2] = fill_log[f0 + i];
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL miss_done got %b exp 1", ok); end
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL miss_latency got %0d exp 10", lat); end
    n_tests++; if (fill_log.size() - f0 !== 4 || fv !== 8'hE4) begin n_fail++; $display("FAIL miss_fill_beats got n=%0d seq=%h exp n=4 seq=e4", fill_log.size() - f0, fv); end
    n_tests++; if (tag_log.size() - t0 !== 1 || tag_log[t0] !== 8'h15) begin n_fail++; $display("FAIL miss_tag_we got n=%0d %h exp n=1 15", tag_log.size() - t0, tag_log[t0]); end
    n_tests++; if (n_ar - a0 !== 1 || n_aw - w0 !== 0) begin n_fail++; $display("FAIL miss_channels got ar=%0d aw=%0d exp ar=1 aw=0", n_ar - a0, n_aw - w0); end
    n_tests++; if (ws !== 2'b01 || fl !== 3'b100) begin n_fail++; $display("FAIL miss_replay got way=%b fl=%b exp 01/100", ws, fl); end
    // Set 5 way1 still invalid: chosen regardless of the pointer.
    ar_delay = 0;
    t0 = tag_log.size();
    do_req(1'b0, 6'd5, 101, lat, ws, fl, ok);
    n_tests++; if (tag_log.size() - t0 !== 1 || tag_log[t0] !== 8'h16) begin n_fail++; $display("FAIL fill_way1 got n=%0d %h exp n=1 16", tag_log.size() - t0, tag_log[t0]); end
    n_tests++; if (ok !== 1'b1 || lat !== 8 || ws !== 2'b10) begin n_fail++; $display("FAIL fill_way1_done got ok=%b lat=%0d way=%b exp 1/8/10", ok, lat, ws); end
  endtask

  task automatic test_store_hit();
    int lat; logic [1:0] ws; logic [2:0] fl; logic ok; int a0;
    preload(6'd3, 1, 77, 1'b0);
    a0 = n_ar;
    do_req(1'b1, 6'd3, 77, lat, ws, fl, ok);
    n_tests++; if (ok !== 1'b1 || lat !== 2) begin n_fail++; $display("FAIL store_hit_latency got ok=%b lat=%0d exp 1/2", ok, lat); end
    n_tests++; if (ws !== 2'b10) begin n_fail++; $display("FAIL store_hit_way got %b exp 10", ws); end
    n_tests++; if (fl !== 3'b011) begin n_fail++; $display("FAIL store_hit_strobes got rd/wr/dset=%b exp 011", fl); end
    n_tests++; if (n_ar !== a0) begin n_fail++; $display("FAIL store_hit_no_ar got %0d exp %0d", n_ar, a0); end
  endtask

  task automatic test_dirty_miss();
    int lat; logic [1:0] ws; logic [2:0] fl; logic ok;
    int w0, aw0, c0, t0, f0, d0; logic [11:0] wv;
    ar_delay = 0; w_toggle = 1'b0;
    do_req(1'b1, 6'd5, 100, lat, ws, fl, ok);
    n_tests++; if (ok !== 1'b1 || ws !== 2'b01 || fl !== 3'b011) begin n_fail++; $display("FAIL dirty_prep got ok=%b way=%b fl=%b exp 1/01/011", ok, ws, fl); end
    w0 = w_log.size(); aw0 = n_aw; c0 = clr_log.size(); t0 = tag_log.size(); f0 = fill_log.size(); d0 = w_drop;
    do_req(1'b0, 6'd5, 102, lat, ws, fl, ok);
    wv = '0;
    for (int i = 0; i < 4; i++) wv[i*3 +: 3] = w_log[w0 + i];
    n_tests++; if (ok !== 1'b1 || lat !== 14) begin n_fail++; $display("FAIL wb_latency got ok=%b lat=%0d exp 1/14", ok, lat); end
    n_tests++; if (n_aw - aw0 !== 1) begin n_fail++; $display("FAIL wb_aw_count got %0d exp 1", n_aw - aw0); end
    n_tests++; if (w_log.size() - w0 !== 4 || wv !== 12'hE88) begin n_fail++; $display("FAIL wb_beats got n=%0d seq=%h exp n=4 seq=e88", w_log.size() - w0, wv); end
    n_tests++; if (clr_log.size() - c0 !== 1 || clr_log[c0] !== 8'h15) begin n_fail++; $display("FAIL wb_dirty_clr got n=%0d %h exp n=1 15", clr_log.size() - c0, clr_log[c0]); end
    n_tests++; if (tag_log.size() - t0 !== 1 || tag_log[t0] !== 8'h15 || fill_log.size() - f0 !== 4) begin n_fail++; $display("FAIL wb_refill got tags=%0d %h fills=%0d exp 1 15 4", tag_log.size() - t0, tag_log[t0], fill_log.size() - f0); end
    n_tests++; if (w_drop !== d0) begin n_fail++; $display("FAIL wb_wvalid_drop got %0d exp %0d", w_drop, d0); end
    n_tests++; if (ws !== 2'b01) begin n_fail++; $display("FAIL wb_replay_way got %b exp 01", ws); end
  endtask

  task automatic test_rr_victim();
    int lat; logic [1:0] ws; logic [2:0] fl; logic ok; int t0, aw0;
    t0 = tag_log.size(); aw0 = n_aw;
    do_req(1'b0, 6'd5, 103, lat, ws, fl, ok);
    n_tests++; if (tag_log.size() - t0 !== 1 || tag_log[t0] !== 8'h16) begin n_fail++; $display("FAIL rr_victim got n=%0d %h exp n=1 16", tag_log.size() - t0, tag_log[t0]); end
    n_tests++; if (n_aw !== aw0 || ok !== 1'b1 || lat !== 8) begin n_fail++; $display("FAIL rr_clean_miss got aw=%0d ok=%b lat=%0d exp %0d/1/8", n_aw, ok, lat, aw0); end
  endtask

  task automatic test_flush();
    int w0, aw0, c0, a0, d0; logic ok; logic [23:0] wv;
    do_reset();
    model_clear();
    preload(6'd0, 1, 11, 1'b1);
    preload(6'd63, 0, 12, 1'b1);
    preload(6'd10, 0, 13, 1'b0);
    preload(6'd20, 1, 14, 1'b0);
    w_toggle = 1'b1;
    w0 = w_log.size(); aw0 = n_aw; c0 = clr_log.size(); a0 = n_ar; d0 = w_drop;
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    n_tests++; if (flush_busy !== 1'b1 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL flush_busy_start got busy=%b ready=%b exp 1/0", flush_busy, cpu_ready); end
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (flush_done) ok = 1'b1;
      else @(negedge clk);
    end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL flush_done_seen got %b exp 1", ok); end
    @(negedge clk);
    n_tests++; if (flush_busy !== 1'b0 || cpu_ready !== 1'b1 || flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_end got busy=%b ready=%b done=%b exp 0/1/0", flush_busy, cpu_ready, flush_done); end
    wv = '0;
    for (int i = 0; i < 8; i++) wv[i*3 +: 3] = w_log[w0 + i];
    n_tests++; if (n_aw - aw0 !== 2 || n_ar !== a0) begin n_fail++; $display("FAIL flush_wb_count got aw=%0d ar=%0d exp 2/0", n_aw - aw0, n_ar - a0); end
    n_tests++; if (w_log.size() - w0 !== 8 || wv !== 24'hE88E88) begin n_fail++; $display("FAIL flush_wbeats got n=%0d seq=%h exp n=8 seq=e88e88", w_log.size() - w0, wv); end
    n_tests++; if (clr_log.size() - c0 !== 2 || clr_log[c0] !== 8'h02 || clr_log[c0+1] !== 8'hFD) begin n_fail++; $display("FAIL flush_clr_pairs got n=%0d %h %h exp n=2 02 fd", clr_log.size() - c0, clr_log[c0], clr_log[c0+1]); end
    n_tests++; if (w_drop !== d0) begin n_fail++; $display("FAIL flush_wvalid_drop got %0d exp %0d", w_drop, d0); end
    w_toggle = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [1:0] ws; logic [2:0] fl; logic ok; int f0, t0;
    ar_delay = 0;
    f0 = fill_log.size();
    @(negedge clk);
    cur_tag = 200; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_idx = 6'd9;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0; cpu_idx = '0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (fill_log.size() - f0 >= 2) ok = 1'b1;
      else @(negedge clk);
    end
    n_tests++; if (ok !== 1'b1 || beat !== 2'd2 || fill_we !== 1'b1) begin n_fail++; $display("FAIL mid_reach_beat2 got ok=%b beat=%0d fill=%b exp 1/2/1", ok, beat, fill_we); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (cpu_ready !== 1'b1 || outs !== 15'h0) begin n_fail++; $display("FAIL mid_reset_outs got ready=%b outs=%h exp 1/0", cpu_ready, outs); end
    n_tests++; if (way_sel !== 2'b00 || beat !== 2'd0 || arr_idx !== 6'd0) begin n_fail++; $display("FAIL mid_reset_bus got way=%b beat=%0d idx=%0d exp 00/0/0", way_sel, beat, arr_idx); end
    rst = 1'b0;
    f0 = fill_log.size(); t0 = tag_log.size();
    do_req(1'b0, 6'd9, 200, lat, ws, fl, ok);
    n_tests++; if (ok !== 1'b1 || lat !== 8 || fill_log.size() - f0 !== 4) begin n_fail++; $display("FAIL mid_recover got ok=%b lat=%0d fills=%0d exp 1/8/4", ok, lat, fill_log.size() - f0); end
    n_tests++; if (tag_log.size() - t0 !== 1 || tag_log[t0] !== 8'h25) begin n_fail++; $display("FAIL mid_recover_tag got n=%0d %h exp n=1 25", tag_log.size() - t0, tag_log[t0]); end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_dirty_miss();
    test_rr_victim();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
